pipelined_cla_addsub: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor for the PID controller datapath, used for error computation and integral accumulation. It generalises the 4-bit lookahead adder to WIDTH bits as a chain of GROUP-bit lookahead blocks, with one register stage per group. It adds a subtract mode, optional signed saturation, status flags and a valid/ready handshake with back-pressure, giving a throughput of one operation per cycle.

---
 rtl/pid_arith_pkg.sv | 29 ++
 rtl/cla_group.sv | 39 +++
 rtl/pipelined_cla_addsub.sv | 128 ++++++++++++
 tb/tb_pipelined_cla_addsub.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pid_arith_pkg.sv
// rtl/pid_arith_pkg.sv - shared arithmetic constants and helpers for the PID datapath
package pid_arith_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Widest datapath sat_value can describe; callers cast the result to their own width.
    localparam int SAT_MAX_W = 128;

    // Signed saturation limit: 0x7F..F for a positive operand A, 0x80..0 for a negative one.
    function automatic logic [SAT_MAX_W-1:0] sat_value(input logic sign, input int width);
        logic [SAT_MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < SAT_MAX_W; i++) begin
            if (i == width - 1) begin
                r[i] = sign;
            end else if (i < width - 1) begin
                r[i] = ~sign;
            end
        end
        return r;
    endfunction

    // Elaboration guard: the operand must split into whole lookahead groups.
    function automatic bit width_ok(input int width, input int group);
        return (group > 0) && (width >= group) && ((width % group) == 0);
    endfunction

endpackage

// File: rtl/cla_group.sv
// rtl/cla_group.sv - combinational GROUP-bit carry-lookahead block
module cla_group #(
    parameter int GROUP = 4
) (
    input  logic [GROUP-1:0] a,
    input  logic [GROUP-1:0] b,
    input  logic             cin,
    output logic [GROUP-1:0] sum,
    output logic             cout,
    output logic             c_top
);

    logic [GROUP-1:0] p;
    logic [GROUP-1:0] g;
    logic [GROUP:0]   c;
    logic             prop;

    // Each carry is a flat sum of products over the group's generate/propagate
    // terms, so no carry depends on another carry inside the block.
    always_comb begin
        p    = a ^ b;
        g    = a & b;
        c    = '0;
        prop = 1'b1;
        for (int i = 0; i <= GROUP; i++) begin
            c[i] = 1'b0;
            prop = 1'b1;
            for (int j = i - 1; j >= 0; j--) begin
                c[i] = c[i] | (g[j] & prop);
                prop = prop & p[j];
            end
            c[i] = c[i] | (cin & prop);
        end
        sum   = p ^ c[GROUP-1:0];
        cout  = c[GROUP];
        c_top = c[GROUP-1];
    end

endmodule

// File: rtl/pipelined_cla_addsub.sv
// rtl/pipelined_cla_addsub.sv - pipelined carry-lookahead adder/subtractor with saturation and handshake
module pipelined_cla_addsub
    import pid_arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    input  logic             in_sat,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             out_ovf,
    output logic             out_zero
);

    localparam int NSTG = WIDTH / GROUP;

    if (!width_ok(WIDTH, GROUP)) begin : g_bad_width
        $error("pipelined_cla_addsub: WIDTH must be a non-zero multiple of GROUP");
    end

    // Slot 0 holds the accepted operands; slot k+1 holds the result of group k.
    // acc holds resolved sum bits below the current group and untouched A bits above.
    logic [NSTG:0]    valid_q, valid_d;
    logic [NSTG:0]    carry_q, carry_d;
    logic [NSTG:0]    sat_q,   sat_d;
    logic [NSTG:0]    amsb_q,  amsb_d;
    logic [WIDTH-1:0] acc_q [NSTG+1];
    logic [WIDTH-1:0] acc_d [NSTG+1];
    logic [WIDTH-1:0] opb_q [NSTG];
    logic [WIDTH-1:0] opb_d [NSTG];
    logic             ovf_q, ovf_d;

    logic [GROUP-1:0] grp_sum  [NSTG];
    logic             grp_cout [NSTG];
    logic             grp_ctop [NSTG];

    logic             adv;
    logic [WIDTH-1:0] res_sum;

    for (genvar k = 0; k < NSTG; k++) begin : g_stage
        cla_group #(
            .GROUP (GROUP)
        ) u_grp (
            .a     (acc_q[k][k*GROUP +: GROUP]),
            .b     (opb_q[k][k*GROUP +: GROUP]),
            .cin   (carry_q[k]),
            .sum   (grp_sum[k]),
            .cout  (grp_cout[k]),
            .c_top (grp_ctop[k])
        );
    end

    // Whole-pipe stall: every slot moves together, so bubbles stay where they are.
    assign adv      = out_ready | ~valid_q[NSTG];
    assign in_ready = adv & ~rst;

    always_comb begin
        valid_d = valid_q;
        carry_d = carry_q;
        sat_d   = sat_q;
        amsb_d  = amsb_q;
        acc_d   = acc_q;
        opb_d   = opb_q;
        ovf_d   = ovf_q;
        if (adv) begin
            valid_d[0] = in_valid;
            acc_d[0]   = in_a;
            opb_d[0]   = (in_sub == MODE_ADD) ? in_b : ~in_b;
            carry_d[0] = (in_sub == MODE_SUB) ? 1'b1 : in_cin;
            sat_d[0]   = in_sat;
            amsb_d[0]  = in_a[WIDTH-1];
            for (int k = 0; k < NSTG; k++) begin
                valid_d[k+1]                      = valid_q[k];
                carry_d[k+1]                      = grp_cout[k];
                sat_d[k+1]                        = sat_q[k];
                amsb_d[k+1]                       = amsb_q[k];
                acc_d[k+1]                        = acc_q[k];
                acc_d[k+1][k*GROUP +: GROUP]      = grp_sum[k];
            end
            for (int k = 1; k < NSTG; k++) begin
                opb_d[k] = opb_q[k-1];
            end
            // Only the top group sees the sign bit, so overflow is captured there.
            ovf_d = grp_ctop[NSTG-1] ^ grp_cout[NSTG-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    always_ff @(posedge clk) begin
        carry_q <= carry_d;
        sat_q   <= sat_d;
        amsb_q  <= amsb_d;
        acc_q   <= acc_d;
        opb_q   <= opb_d;
        ovf_q   <= ovf_d;
    end

    always_comb begin
        res_sum = acc_q[NSTG];
        if (sat_q[NSTG] && ovf_q) begin
            res_sum = WIDTH'(sat_value(amsb_q[NSTG], WIDTH));
        end
    end

    assign out_valid = valid_q[NSTG];
    assign out_sum   = out_valid ? res_sum : '0;
    assign out_cout  = out_valid & carry_q[NSTG];
    assign out_ovf   = out_valid & ovf_q;
    assign out_zero  = out_valid & (res_sum == '0);

endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// tb/tb_pipelined_cla_addsub.sv - self-checking bench for pipelined_cla_addsub
module tb_pipelined_cla_addsub;

    localparam int WIDTH = 16;
    localparam int GROUP = 4;
    localparam int LAT   = 4;

    typedef struct packed {
        logic [15:0] s;
        logic        c;
        logic        o;
        logic        z;
    } res_t;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             in_sub;
    logic             in_sat;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;
    logic             out_zero;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    pipelined_cla_addsub #(
        .WIDTH (WIDTH),
        .GROUP (GROUP)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .in_sat    (in_sat),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .out_ovf   (out_ovf),
        .out_zero  (out_zero)
    );

    function automatic res_t model(input logic [15:0] a, input logic [15:0] b,
                                   input logic cin, input logic sub, input logic sat);
        logic [15:0] bb;
        logic [16:0] full;
        res_t        r;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {16'd0, (sub ? 1'b1 : cin)};
        r.s  = full[15:0];
        r.c  = full[16];
        r.o  = (a[15] == bb[15]) && (full[15] != a[15]);
        if (sat && r.o) r.s = a[15] ? 16'h8000 : 16'h7FFF;
        r.z  = (r.s == 16'h0000);
        return r;
    endfunction

    task automatic run_op(input logic [15:0] a, input logic [15:0] b, input logic cin,
                          input logic sub, input logic sat, output res_t r, output int lat);
        int w;
        @(negedge clk);
        in_a = a; in_b = b; in_cin = cin; in_sub = sub; in_sat = sat; in_valid = 1'b1;
        #1;
        w = 0;
        while (in_ready !== 1'b1 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (out_valid !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        r = '{s: out_sum, c: out_cout, o: out_ovf, z: out_zero};
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        in_a = '0; in_b = '0; in_cin = 1'b0; in_sub = 1'b0; in_sat = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL reset_in_ready_during_rst: got %b want 0", in_ready); else passed++;
        rst = 1'b0;
        @(negedge clk);
        #1;
        total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b want 0", out_valid); else passed++;
        total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", in_ready); else passed++;
        total++; if (out_sum !== 16'h0000) $display("FAIL reset_out_sum: got %h want 0000", out_sum); else passed++;
        total++; if (out_cout !== 1'b0) $display("FAIL reset_out_cout: got %b want 0", out_cout); else passed++;
        total++; if (out_ovf !== 1'b0) $display("FAIL reset_out_ovf: got %b want 0", out_ovf); else passed++;
        total++; if (out_zero !== 1'b0) $display("FAIL reset_out_zero: got %b want 0", out_zero); else passed++;
    endtask

    task automatic test_add();
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        logic        tc [3];
        res_t        te [3];
        res_t        r;
        int          lat;
        ta = '{16'h1234, 16'hFFFF, 16'h0001};
        tb = '{16'h0FFF, 16'h0001, 16'h0001};
        tc = '{1'b0, 1'b0, 1'b1};
        te = '{'{16'h2233, 1'b0, 1'b0, 1'b0},
               '{16'h0000, 1'b1, 1'b0, 1'b1},
               '{16'h0003, 1'b0, 1'b0, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], tc[i], 1'b0, 1'b0, r, lat);
            total++; if (lat != LAT) $display("FAIL add_latency[%0d]: got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (r.s !== te[i].s) $display("FAIL add_sum[%0d]: got %h want %h", i, r.s, te[i].s); else passed++;
            total++; if (r.c !== te[i].c) $display("FAIL add_cout[%0d]: got %b want %b", i, r.c, te[i].c); else passed++;
            total++; if (r.o !== te[i].o) $display("FAIL add_ovf[%0d]: got %b want %b", i, r.o, te[i].o); else passed++;
            total++; if (r.z !== te[i].z) $display("FAIL add_zero[%0d]: got %b want %b", i, r.z, te[i].z); else passed++;
        end
    endtask

    task automatic test_sub();
        logic [15:0] ta [3];
        logic [15:0] tb [3];
        res_t        te [3];
        res_t        r;
        int          lat;
        ta = '{16'h0005, 16'h0007, 16'h0007};
        tb = '{16'h0007, 16'h0005, 16'h0007};
        te = '{'{16'hFFFE, 1'b0, 1'b0, 1'b0},
               '{16'h0002, 1'b1, 1'b0, 1'b0},
               '{16'h0000, 1'b1, 1'b0, 1'b1}};
        for (int i = 0; i < 3; i++) begin
            run_op(ta[i], tb[i], 1'b0, 1'b1, 1'b0, r, lat);
            total++; if (lat != LAT) $display("FAIL sub_latency[%0d]: got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (r.s !== te[i].s) $display("FAIL sub_sum[%0d]: got %h want %h", i, r.s, te[i].s); else passed++;
            total++; if (r.c !== te[i].c) $display("FAIL sub_cout[%0d]: got %b want %b", i, r.c, te[i].c); else passed++;
            total++; if (r.o !== te[i].o) $display("FAIL sub_ovf[%0d]: got %b want %b", i, r.o, te[i].o); else passed++;
            total++; if (r.z !== te[i].z) $display("FAIL sub_zero[%0d]: got %b want %b", i, r.z, te[i].z); else passed++;
        end
    endtask

    task automatic test_saturation();
        logic [15:0] ta [5];
        logic [15:0] tb [5];
        logic        ts [5];
        logic        tt [5];
        res_t        te [5];
        res_t        r;
        int          lat;
        ta = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h1000, 16'h8000};
        tb = '{16'h0001, 16'h0001, 16'h0001, 16'h1000, 16'hFFFF};
        ts = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        tt = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        te = '{'{16'h8000, 1'b0, 1'b1, 1'b0},
               '{16'h7FFF, 1'b0, 1'b1, 1'b0},
               '{16'h8000, 1'b1, 1'b1, 1'b0},
               '{16'h2000, 1'b0, 1'b0, 1'b0},
               '{16'h8000, 1'b1, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            run_op(ta[i], tb[i], 1'b0, ts[i], tt[i], r, lat);
            total++; if (lat != LAT) $display("FAIL sat_latency[%0d]: got %0d want %0d", i, lat, LAT); else passed++;
            total++; if (r.s !== te[i].s) $display("FAIL sat_sum[%0d]: got %h want %h", i, r.s, te[i].s); else passed++;
            total++; if (r.c !== te[i].c) $display("FAIL sat_cout[%0d]: got %b want %b", i, r.c, te[i].c); else passed++;
            total++; if (r.o !== te[i].o) $display("FAIL sat_ovf[%0d]: got %b want %b", i, r.o, te[i].o); else passed++;
            total++; if (r.z !== te[i].z) $display("FAIL sat_zero[%0d]: got %b want %b", i, r.z, te[i].z); else passed++;
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] oa [8];
        logic [15:0] ob [8];
        logic        oc [8];
        logic        os [8];
        logic        ot [8];
        res_t        exp_q [$];
        res_t        r;
        res_t        hold;
        int          sent = 0;
        int          got = 0;
        int          cyc = 0;
        logic        stalled_prev = 1'b0;
        for (int i = 0; i < 8; i++) begin
            oa[i] = 16'($urandom);
            ob[i] = 16'($urandom);
            oc[i] = 1'($urandom);
            os[i] = 1'($urandom);
            ot[i] = 1'($urandom);
        end
        hold = '0;
        while (got < 8 && cyc < 80) begin
            @(negedge clk);
            out_ready = !(cyc >= 6 && cyc <= 8);
            if (sent < 8) begin
                in_a = oa[sent]; in_b = ob[sent]; in_cin = oc[sent];
                in_sub = os[sent]; in_sat = ot[sent]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            total++; if (in_ready !== (out_ready | ~out_valid)) $display("FAIL bp_in_ready[cyc %0d]: got %b want %b", cyc, in_ready, out_ready | ~out_valid); else passed++;
            if (stalled_prev) begin
                total++; if (out_valid !== 1'b1) $display("FAIL bp_hold_valid[cyc %0d]: got %b want 1", cyc, out_valid); else passed++;
                total++; if ({out_sum, out_cout, out_ovf, out_zero} !== hold) $display("FAIL bp_hold_data[cyc %0d]: got %h want %h", cyc, {out_sum, out_cout, out_ovf, out_zero}, hold); else passed++;
            end
            if (out_valid === 1'b1) begin
                if (out_ready) begin
                    total++;
                    if (exp_q.size() == 0) begin
                        $display("FAIL bp_extra_result[cyc %0d]: got %h want none", cyc, out_sum);
                    end else begin
                        r = exp_q.pop_front();
                        if ({out_sum, out_cout, out_ovf, out_zero} !== r) $display("FAIL bp_result[%0d]: got %h want %h", got, {out_sum, out_cout, out_ovf, out_zero}, r); else passed++;
                    end
                    got++;
                end else begin
                    hold = '{s: out_sum, c: out_cout, o: out_ovf, z: out_zero};
                end
            end
            stalled_prev = (out_valid === 1'b1) && !out_ready;
            if (sent < 8 && in_ready === 1'b1) begin
                exp_q.push_back(model(oa[sent], ob[sent], oc[sent], os[sent], ot[sent]));
                sent++;
            end
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        total++; if (got != 8) $display("FAIL bp_result_count: got %0d want 8", got); else passed++;
        total++; if (exp_q.size() != 0) $display("FAIL bp_pending: got %0d want 0", exp_q.size()); else passed++;
    endtask

    task automatic test_reset_mid_stream();
        res_t r;
        int   lat;
        int   seen = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            in_a = 16'h0100 * 16'(i + 1); in_b = 16'h0011; in_cin = 1'b0;
            in_sub = 1'b0; in_sat = 1'b0; in_valid = 1'b1;
            #1;
            total++; if (in_ready !== 1'b1) $display("FAIL rst_mid_accept[%0d]: got %b want 1", i, in_ready); else passed++;
        end
        @(negedge clk);
        rst = 1'b1;
        in_a = 16'h0F00;
        #1;
        total++; if (in_ready !== 1'b0) $display("FAIL rst_mid_in_ready: got %b want 0", in_ready); else passed++;
        @(negedge clk);
        rst = 1'b0;
        in_valid = 1'b0;
        total++; if (out_valid !== 1'b0) $display("FAIL rst_mid_out_valid: got %b want 0", out_valid); else passed++;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen++;
        end
        total++; if (seen != 0) $display("FAIL rst_mid_flushed: got %0d stale results want 0", seen); else passed++;
        run_op(16'h0100, 16'h0020, 1'b0, 1'b0, 1'b0, r, lat);
        total++; if (lat != LAT) $display("FAIL rst_mid_latency: got %0d want %0d", lat, LAT); else passed++;
        total++; if (r.s !== 16'h0120) $display("FAIL rst_mid_sum: got %h want 0120", r.s); else passed++;
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_saturation();
        test_back_to_back();
        test_reset_mid_stream();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
